noc_output_scheduler: RTL and testbench
=======================================

// Module: noc_output_scheduler
// PURPOSE
//   Per-output-port packet scheduler for the 5-port NoC router (L,N,E,W,S).
//   Grants one input at a time using round-robin order. Holds the grant for a whole packet (header..tail).
//   Gates flit transfer on downstream credits. Optionally releases a stalled owner after a watchdog timeout.
//   Sits between the input buffers and the crossbar select for one output.
// PARAMETERS
//   NPORTS     5   number of requesters; bit order L=0,N=1,E=2,W=3,S=4
//   CREDITS    4   downstream buffer depth; credit counter reset/max value
//   TIMEOUT_W  12  width of the watchdog count and of timeout_cycles
// PORTS
//   clk             in   1           clock, rising edge
//   rst             in   1           synchronous reset, active-high
//   req             in   NPORTS      head flit valid per input
//   flit_id         in   3*NPORTS    head flit id per input; [3i+2:3i] belongs to port i
//   credit_ret      in   1           downstream freed one buffer slot this cycle
//   timeout_cycles  in   TIMEOUT_W   watchdog limit; 0 disables the watchdog
//   grant           out  NPORTS      one-hot registered owner (all zero when idle)
//   xfer            out  1           combinational: owner flit moves this cycle
//   credits         out  $clog2(CREDITS+1)  current downstream credit count
//   timeout_pulse   out  1           1-cycle pulse when the watchdog releases the owner
//   proto_err       out  1           sticky: non-header flit at idle, or credit overflow
// BEHAVIOUR
//   - Reset: grant=0, credits=CREDITS, timeout_pulse=0, proto_err=0, rr_ptr=0, state=IDLE. Reset mid-packet drops the packet and loses its credits.
//   - flit_id decode: bit0=header, bit1=body, bit2=tail. 3'b101 is a single-flit packet.
//   - State IDLE:
//     - Candidates are ports with req=1 and header bit set.
//     - Pick the first candidate searching upward from rr_ptr, wrapping at NPORTS-1.
//     - Next cycle: grant=onehot(pick), state=LOCKED. Request-to-grant latency is 1 cycle. No xfer in IDLE.
//     - Any req=1 with header bit clear sets proto_err; that port is not granted.
//   - State LOCKED:
//     - xfer = req[owner] & (credits!=0).
//     - If xfer and the owner flit has the tail bit set: next state=IDLE, grant=0, rr_ptr=(owner+1) mod NPORTS.
//     - Back-to-back packets therefore have at least 1 idle cycle between tail and next grant.
//   - Credits:
//     - xfer alone decrements; credit_ret alone increments; both together leaves credits unchanged.
//     - credit_ret while credits==CREDITS and no xfer saturates the count and sets proto_err.
//     - Credits never go below 0, because xfer requires credits!=0.
//   - Watchdog (only with the macro below):
//     - wd_cnt clears on any xfer and in IDLE; it increments each LOCKED cycle with no xfer.
//     - When wd_cnt==timeout_cycles and timeout_cycles!=0: grant=0, state=IDLE, rr_ptr=owner+1, timeout_pulse=1 for one cycle.
//     - Tail xfer and timeout in the same cycle: the tail wins and there is no pulse.
//   - proto_err clears only on rst.
// CONFIGURATION
//   NOC_SCHED_WATCHDOG_EN
//     - Defined: watchdog logic as above.
//     - Undefined: no wd_cnt; timeout_cycles is ignored; timeout_pulse is tied 0. The owner holds until tail.
// STRUCTURE
//   - Shared package noc_pkg:
//     - FLIT_HDR/FLIT_BODY/FLIT_TAIL bit positions
//     - port index localparams (PORT_L..PORT_S)
//     - sched_state_t enum {IDLE, LOCKED}
//   - Sub-module noc_rr_pick: combinational round-robin picker. Inputs: cand[NPORTS] and ptr. Outputs: onehot and valid.
//   - The remaining FSM, credit counter and watchdog stay in this module.
// TESTING
//   - Reset, then req=5'b00110 with headers, rr_ptr=0 -> grant=5'b00010 one cycle later; after N tail, next grant 5'b00100.
//   - 3-flit packet from S, credits=4, no credit_ret -> 3 xfers, credits=1, grant drops the cycle after the tail.
//   - credits=0 with owner req=1 -> xfer=0 and hold; credit_ret pulse -> xfer next cycle; xfer+credit_ret together -> credits unchanged.
//   - Body flit on E while IDLE -> no grant, proto_err=1 and stays 1 until rst; credit_ret at credits=4 -> proto_err=1, credits=4.
//   - Watchdog build, timeout_cycles=3, owner W stalls after its header -> timeout_pulse on the 3rd stall cycle, grant=0, next pick starts at S.
//   - rst asserted while LOCKED mid-packet -> grant=0, credits=4 on the next edge; a fresh header is granted normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC scheduler definitions: flit-type bit positions, port indices and the
// scheduler state encoding.
package noc_pkg;

    localparam int FLIT_HDR  = 0;
    localparam int FLIT_BODY = 1;
    localparam int FLIT_TAIL = 2;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: the first set candidate found searching upward
// from ptr, wrapping past NPORTS-1 back to 0.
module noc_rr_pick #(
    parameter int NPORTS = 5,
    parameter int PTR_W  = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] cand,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NPORTS-1:0] onehot,
    output logic              valid
);

    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    always_comb begin
        int              sum;
        logic [PTR_W-1:0] idx;
        onehot = '0;
        valid  = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NPORTS) sum = sum - NPORTS;
            idx = PTR_W'(sum);
            if (!valid && cand[idx]) begin
                onehot[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_scheduler.sv
// Per-output packet scheduler: round-robin grant held header..tail, credit-gated transfer.
// Optional owner watchdog enabled by defining NOC_SCHED_WATCHDOG_EN.
module noc_output_scheduler
    import noc_pkg::*;
#(
    parameter int NPORTS    = 5,
    parameter int CREDITS   = 4,
    parameter int TIMEOUT_W = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NPORTS-1:0]              req,
    input  logic [3*NPORTS-1:0]            flit_id,
    input  logic                           credit_ret,
    input  logic [TIMEOUT_W-1:0]           timeout_cycles,
    output logic [NPORTS-1:0]              grant,
    output logic                           xfer,
    output logic [$clog2(CREDITS+1)-1:0]   credits,
    output logic                           timeout_pulse,
    output logic                           proto_err
);

    localparam int PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CRED_W = $clog2(CREDITS + 1);

    sched_state_t      state_q, state_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              proto_err_q, proto_err_d;
    logic              timeout_pulse_q, timeout_pulse_d;

    logic [NPORTS-1:0] hdr_vec, body_vec, tail_vec, cand, pick_onehot;
    logic              pick_valid;
    logic [PTR_W-1:0]  owner_idx, owner_next;
    logic              owner_req, owner_tail, timeout_fire;
    logic              bad_idle_req, credit_ovf;
    logic              unused_body;

    always_comb begin
        hdr_vec  = '0;
        body_vec = '0;
        tail_vec = '0;
        for (int i = 0; i < NPORTS; i++) begin
            hdr_vec[i]  = flit_id[3*i + FLIT_HDR];
            body_vec[i] = flit_id[3*i + FLIT_BODY];
            tail_vec[i] = flit_id[3*i + FLIT_TAIL];
        end
    end

    assign unused_body = ^body_vec;
    assign cand        = req & hdr_vec;

    noc_rr_pick #(
        .NPORTS (NPORTS),
        .PTR_W  (PTR_W)
    ) u_pick (
        .cand   (cand),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .valid  (pick_valid)
    );

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) owner_idx = PTR_W'(i);
        end
    end

    assign owner_next = (owner_idx == PTR_W'(NPORTS - 1)) ? '0 : owner_idx + PTR_W'(1);
    assign owner_req  = |(req & grant_q);
    assign owner_tail = |(tail_vec & grant_q);

`ifdef NOC_SCHED_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d, wd_inc;

    // The release fires on the stall cycle that brings the count up to timeout_cycles.
    always_comb begin
        wd_inc       = wd_cnt_q + TIMEOUT_W'(1);
        timeout_fire = (state_q == LOCKED) && !xfer &&
                       (timeout_cycles != '0) && (wd_inc == timeout_cycles);
        wd_cnt_d     = (state_q != LOCKED || xfer || timeout_fire) ? '0 : wd_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) wd_cnt_q <= '0;
        else     wd_cnt_q <= wd_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_fire   = 1'b0;
`endif

    // Output logic: flits move only while locked and downstream has space.
    always_comb begin
        xfer = (state_q == LOCKED) && owner_req && (credits_q != '0);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LOCKED;
                    grant_d = pick_onehot;
                end
            end
            LOCKED: begin
                if ((xfer && owner_tail) || timeout_fire) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bad_idle_req = (state_q == IDLE) && |(req & ~hdr_vec);
        credit_ovf   = credit_ret && !xfer && (credits_q == CRED_W'(CREDITS));
        credits_d    = credits_q;
        if (xfer && !credit_ret)
            credits_d = credits_q - CRED_W'(1);
        else if (credit_ret && !xfer && !credit_ovf)
            credits_d = credits_q + CRED_W'(1);
        proto_err_d     = proto_err_q | bad_idle_req | credit_ovf;
        timeout_pulse_d = timeout_fire;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            rr_ptr_q        <= '0;
            credits_q       <= CRED_W'(CREDITS);
            proto_err_q     <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rr_ptr_q        <= rr_ptr_d;
            credits_q       <= credits_d;
            proto_err_q     <= proto_err_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign grant         = grant_q;
    assign credits       = credits_q;
    assign proto_err     = proto_err_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Self-checking bench for noc_output_scheduler: directed vector table, watchdog sequence
// (behaviour follows NOC_SCHED_WATCHDOG_EN) and randomized run against a reference model.
module tb_noc_output_scheduler;

    localparam int NP = 5;
    localparam int CR = 4;
    localparam int TW = 12;

    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] B  = 3'b010;
    localparam logic [2:0] T  = 3'b100;
    localparam logic [2:0] S1 = 3'b101;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req;
    logic [3*NP-1:0] flit_id;
    logic            credit_ret;
    logic [TW-1:0]   timeout_cycles;
    logic [NP-1:0]   grant;
    logic            xfer;
    logic [2:0]      credits;
    logic            timeout_pulse;
    logic            proto_err;

    int errors = 0;
    int checks = 0;

    noc_output_scheduler #(.NPORTS(NP), .CREDITS(CR), .TIMEOUT_W(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .flit_id        (flit_id),
        .credit_ret     (credit_ret),
        .timeout_cycles (timeout_cycles),
        .grant          (grant),
        .xfer           (xfer),
        .credits        (credits),
        .timeout_pulse  (timeout_pulse),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [NP-1:0]   req;
        logic [3*NP-1:0] fl;
        logic            cret;
        logic            exp_xfer;
        logic [NP-1:0]   exp_grant;
        int              exp_cred;
        logic            exp_proto;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3*NP-1:0] fid(input int p, input logic [2:0] code);
        logic [3*NP-1:0] v;
        v = '0;
        v[3*p +: 3] = code;
        return v;
    endfunction

    function automatic vec_t mk(input logic r, input logic [NP-1:0] rq, input logic [3*NP-1:0] fl,
                                input logic cr, input logic ex, input logic [NP-1:0] eg,
                                input int ec, input logic ep);
        vec_t v;
        v.rst = r; v.req = rq; v.fl = fl; v.cret = cr;
        v.exp_xfer = ex; v.exp_grant = eg; v.exp_cred = ec; v.exp_proto = ep;
        return v;
    endfunction

    task automatic cyc(input logic r, input logic [NP-1:0] rq, input logic [3*NP-1:0] fl, input logic cr);
        @(negedge clk);
        rst = r; req = rq; flit_id = fl; credit_ret = cr;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: owner -1 means no packet is being served.
    int m_owner, m_rr, m_cred, m_stall;
    logic m_proto, m_pulse;

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_cred = CR; m_stall = 0; m_proto = 1'b0; m_pulse = 1'b0;
    endtask

    function automatic logic model_xfer();
        return (m_owner >= 0) && req[m_owner] && (m_cred > 0);
    endfunction

    task automatic model_step();
        logic x;
        int   p;
        x = model_xfer();
        if (rst) begin
            model_reset();
            return;
        end
        m_pulse = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < NP; i++)
                if (req[i] && !flit_id[3*i]) m_proto = 1'b1;
            for (int k = 0; k < NP; k++) begin
                p = (m_rr + k) % NP;
                if (m_owner < 0 && req[p] && flit_id[3*p]) m_owner = p;
            end
            m_stall = 0;
        end else if (x && flit_id[3*m_owner+2]) begin
            m_rr = (m_owner + 1) % NP;
            m_owner = -1;
            m_stall = 0;
        end else if (x) begin
            m_stall = 0;
        end else begin
`ifdef NOC_SCHED_WATCHDOG_EN
            m_stall = (m_stall + 1) % (1 << TW);
            if (timeout_cycles != 0 && m_stall == int'(timeout_cycles)) begin
                m_pulse = 1'b1;
                m_rr = (m_owner + 1) % NP;
                m_owner = -1;
                m_stall = 0;
            end
`endif
        end
        if (x && !credit_ret) m_cred--;
        else if (credit_ret && !x) begin
            if (m_cred == CR) m_proto = 1'b1;
            else m_cred++;
        end
    endtask

    initial begin
        logic [2:0] codes[8];
        logic [NP-1:0] eg;
        codes[0] = H; codes[1] = H; codes[2] = S1; codes[3] = B;
        codes[4] = T; codes[5] = H; codes[6] = S1; codes[7] = 3'b000;

        rst = 1'b1; req = '0; flit_id = '0; credit_ret = 1'b0; timeout_cycles = '0;

        // Directed table: inputs held for one cycle; xfer checked before the edge, state after.
        tv.push_back(mk(1, 5'b00000, '0, 0, 0, 5'b00000, 4, 0));
        tv.push_back(mk(0, 5'b00110, fid(1,H)|fid(2,H), 0, 0, 5'b00010, 4, 0));
        tv.push_back(mk(0, 5'b00110, fid(1,H)|fid(2,H), 0, 1, 5'b00010, 3, 0));
        tv.push_back(mk(0, 5'b00110, fid(1,T)|fid(2,H), 0, 1, 5'b00000, 2, 0));
        tv.push_back(mk(0, 5'b00100, fid(2,H), 0, 0, 5'b00100, 2, 0));
        tv.push_back(mk(0, 5'b00100, fid(2,S1), 0, 1, 5'b00000, 1, 0));
        tv.push_back(mk(0, 5'b00000, '0, 1, 0, 5'b00000, 2, 0));
        tv.push_back(mk(0, 5'b00000, '0, 1, 0, 5'b00000, 3, 0));
        tv.push_back(mk(0, 5'b00000, '0, 1, 0, 5'b00000, 4, 0));
        tv.push_back(mk(0, 5'b00000, '0, 1, 0, 5'b00000, 4, 1));
        tv.push_back(mk(1, 5'b00000, '0, 0, 0, 5'b00000, 4, 0));
        tv.push_back(mk(0, 5'b10000, fid(4,H), 0, 0, 5'b10000, 4, 0));
        tv.push_back(mk(0, 5'b10000, fid(4,H), 0, 1, 5'b10000, 3, 0));
        tv.push_back(mk(0, 5'b10000, fid(4,B), 0, 1, 5'b10000, 2, 0));
        tv.push_back(mk(0, 5'b10000, fid(4,T), 0, 1, 5'b00000, 1, 0));
        tv.push_back(mk(0, 5'b00001, fid(0,H), 0, 0, 5'b00001, 1, 0));
        tv.push_back(mk(0, 5'b00001, fid(0,H), 0, 1, 5'b00001, 0, 0));
        tv.push_back(mk(0, 5'b00001, fid(0,B), 0, 0, 5'b00001, 0, 0));
        tv.push_back(mk(0, 5'b00001, fid(0,B), 1, 0, 5'b00001, 1, 0));
        tv.push_back(mk(0, 5'b00001, fid(0,B), 1, 1, 5'b00001, 1, 0));
        tv.push_back(mk(0, 5'b00001, fid(0,T), 0, 1, 5'b00000, 0, 0));
        tv.push_back(mk(0, 5'b00100, fid(2,B), 0, 0, 5'b00000, 0, 1));
        tv.push_back(mk(0, 5'b00000, '0, 0, 0, 5'b00000, 0, 1));
        tv.push_back(mk(0, 5'b00000, '0, 1, 0, 5'b00000, 1, 1));
        tv.push_back(mk(1, 5'b00000, '0, 0, 0, 5'b00000, 4, 0));
        tv.push_back(mk(0, 5'b01000, fid(3,H), 0, 0, 5'b01000, 4, 0));
        tv.push_back(mk(0, 5'b01000, fid(3,H), 0, 1, 5'b01000, 3, 0));
        tv.push_back(mk(1, 5'b00000, '0, 0, 0, 5'b00000, 4, 0));
        tv.push_back(mk(0, 5'b01000, fid(3,H), 0, 0, 5'b01000, 4, 0));
        tv.push_back(mk(0, 5'b01000, fid(3,S1), 0, 1, 5'b00000, 3, 0));
        tv.push_back(mk(0, 5'b00011, fid(0,H)|fid(1,H), 0, 0, 5'b00001, 3, 0));
        tv.push_back(mk(0, 5'b00011, fid(0,S1)|fid(1,H), 0, 1, 5'b00000, 2, 0));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst = tv[i].rst; req = tv[i].req; flit_id = tv[i].fl; credit_ret = tv[i].cret;
            #1;
            check($sformatf("vec%0d xfer", i), 32'(xfer), 32'(tv[i].exp_xfer));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d grant", i), 32'(grant), 32'(tv[i].exp_grant));
            check($sformatf("vec%0d credits", i), 32'(credits), 32'(tv[i].exp_cred));
            check($sformatf("vec%0d proto_err", i), 32'(proto_err), 32'(tv[i].exp_proto));
            check($sformatf("vec%0d timeout_pulse", i), 32'(timeout_pulse), 32'd0);
        end

        // Watchdog: W owns, sends its header, then stalls for three cycles.
        cyc(1, '0, '0, 0);
        timeout_cycles = TW'(3);
        cyc(0, 5'b01000, fid(3,H), 0);
        check("wd grant W", 32'(grant), 32'(5'b01000));
        cyc(0, 5'b01000, fid(3,H), 0);
        check("wd header xfer credits", 32'(credits), 32'd3);
        cyc(0, '0, '0, 0);
        check("wd stall1 grant", 32'(grant), 32'(5'b01000));
        check("wd stall1 pulse", 32'(timeout_pulse), 32'd0);
        cyc(0, '0, '0, 0);
        check("wd stall2 grant", 32'(grant), 32'(5'b01000));
        check("wd stall2 pulse", 32'(timeout_pulse), 32'd0);
        cyc(0, '0, '0, 0);
`ifdef NOC_SCHED_WATCHDOG_EN
        check("wd stall3 grant", 32'(grant), 32'd0);
        check("wd stall3 pulse", 32'(timeout_pulse), 32'd1);
        cyc(0, 5'b10001, fid(0,H)|fid(4,H), 0);
        check("wd next pick S", 32'(grant), 32'(5'b10000));
        check("wd pulse one cycle", 32'(timeout_pulse), 32'd0);
`else
        check("hold stall3 grant", 32'(grant), 32'(5'b01000));
        check("hold stall3 pulse", 32'(timeout_pulse), 32'd0);
        cyc(0, 5'b10001, fid(0,H)|fid(4,H), 0);
        check("hold still W", 32'(grant), 32'(5'b01000));
        cyc(0, 5'b01000, fid(3,T), 0);
        check("hold tail release", 32'(grant), 32'd0);
        check("hold no pulse", 32'(timeout_pulse), 32'd0);
`endif

        // Randomized run against the reference model.
        timeout_cycles = TW'($urandom_range(2, 5));
        cyc(1, '0, '0, 0);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 99) < 3);
            credit_ret = ($urandom_range(0, 99) < 30);
            for (int p = 0; p < NP; p++) begin
                req[p]            = ($urandom_range(0, 1) == 1);
                flit_id[3*p +: 3] = codes[$urandom_range(0, 7)];
            end
            #1;
            check("rand xfer", 32'(xfer), 32'(model_xfer()));
            model_step();
            @(posedge clk);
            #1;
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            check("rand grant", 32'(grant), 32'(eg));
            check("rand credits", 32'(credits), 32'(m_cred));
            check("rand proto_err", 32'(proto_err), 32'(m_proto));
            check("rand timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
